// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads instruction memory over a req/ready
// handshake and feeds IF/ID from a one-entry buffer. Optional halt opcode support: FETCH_HALT_EN.
module if_fetch_unit #(
  parameter int                 PC_W        = 8,
  parameter int                 INSTR_W     = 19,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = '0,
  parameter logic [PC_W-1:0]    RESET_PC    = '0,
  parameter logic [4:0]         HALT_OPCODE = 5'h1F
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               IF_IDwrite,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] IF_instruction,
  output logic [PC_W-1:0]    IF_pc_plus_one,
  output logic               IF_valid,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ppo_q, ppo_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;

  logic [PC_W-1:0]    pc_plus;
  logic               fetch_done;
  logic               halt_hit;

  assign pc_plus  = pc_q + PC_W'(1);
  assign halt_hit = (imem_rdata[INSTR_W-1 -: 5] == HALT_OPCODE);

  // rst_n gates the request directly so an in-flight fetch is dropped the instant reset asserts
  assign imem_req   = rst_n && (state_q == S_RUN) && !branch_taken && (!valid_q || IF_IDwrite);
  assign fetch_done = imem_req && imem_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ppo_d    = ppo_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    if (state_q == S_BOOT) begin
      state_d = S_RUN;
    end

    if (branch_taken) begin
      pc_d     = branch_target;
      valid_d  = 1'b0;
      instr_d  = NOP_INSTR;
      halted_d = 1'b0;
      if (state_q == S_HALT) begin
        state_d = S_RUN;
      end
    end else if (fetch_done) begin
      instr_d = imem_rdata;
      ppo_d   = pc_plus;
      valid_d = 1'b1;
      // A halt instruction is delivered but the PC parks on it until a redirect
      if (HALT_EN && halt_hit) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end else begin
        pc_d = pc_plus;
      end
    end else if (IF_IDwrite) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      ppo_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ppo_q    <= ppo_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign IF_instruction = instr_q;
  assign IF_pc_plus_one = ppo_q;
  assign IF_valid       = valid_q;
  assign halted         = HALT_EN ? halted_q : 1'b0;

endmodule
